// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state type for the sequential binary-to-BCD converter
package bcd_pkg;

    localparam int BCD_DIGITS = 5;
    localparam int DIGIT_W    = 4;
    localparam int CNT_W      = 5;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] in_i,
    output logic [DIGIT_W-1:0] out_o
);

    // A digit >= 5 would overflow past 9 after the next shift, so pre-correct it.
    always_comb begin
        out_o = in_i;
        if (in_i >= DIGIT_W'(5)) begin
            out_o = in_i + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin16_to_bcd_seq.sv
// rtl/bin16_to_bcd_seq.sv - sequential double-dabble converter, one bit per cycle; optional blanking via BCD_BLANK_EN
module bin16_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic [4:0]  blank,
    output logic        busy,
    output logic        done
);

    localparam int               BCD_W    = BCD_DIGITS * DIGIT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   shift_q;
    logic [BIN_W-1:0]   shift_d;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   scratch_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               done_q;
    logic               unused_msb;

    // Per-digit add-3 correction on the current scratch value.
    for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (scratch_q[k*DIGIT_W +: DIGIT_W]),
            .out_o (adj[k*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected scratch and shift register move left as one; the top scratch bit is always zero here.
    assign {unused_msb, scratch_d, shift_d} = {adj, shift_q, 1'b0};

`ifdef BCD_BLANK_EN
    logic [BCD_DIGITS-1:0] blank_d;
    logic [BCD_DIGITS-1:0] blank_q;
    logic                  all_zero;

    // Leading-zero mask: digit k is blank when it and every digit above it are zero; units never blank.
    always_comb begin
        blank_d  = '0;
        all_zero = 1'b1;
        for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero & (scratch_d[k*DIGIT_W +: DIGIT_W] == '0);
            blank_d[k] = all_zero;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    // Control FSM and datapath registers; result and flags are registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= bin[BIN_W-1:0];
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        bcd_q   <= scratch_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef BCD_BLANK_EN
                        blank_q <= blank_d;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// tb/tb_bin16_to_bcd_seq.sv - scoreboard bench for bin16_to_bcd_seq with a decimal-arithmetic reference
module tb_bin16_to_bcd_seq;

    localparam int BIN_W = 16;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  blank;
        int          cyc;
        int          val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        busy;
    logic        done;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic [19:0] last_bcd = '0;

    bin16_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .blank (blank),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] b;
        int p;
        b = '0;
        p = 1;
`ifdef BCD_BLANK_EN
        for (int k = 1; k < 5; k++) begin
            p = p * 10;
            b[k] = (v < p);
        end
`endif
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue the expected result for a start that the next posedge will accept.
    task automatic push_exp(input int v);
        exp_t e;
        int m;
        m = v & ((1 << BIN_W) - 1);
        e.bcd   = ref_bcd(m);
        e.blank = ref_blank(m);
        e.cyc   = cyc + 1 + BIN_W;
        e.val   = m;
        sb.push_back(e);
    endtask

    // Monitor: every done pops one expectation; bcd must not move between dones.
    always @(negedge clk) begin
        if (rst) begin
            last_bcd = bcd;
        end else if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with bcd=%0h expected no done (cycle %0d)", bcd, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("bcd[%0d]", e.val), 32'(bcd), 32'(e.bcd));
                chk($sformatf("blank[%0d]", e.val), 32'(blank), 32'(e.blank));
                chk($sformatf("latency[%0d]", e.val), 32'(cyc), 32'(e.cyc));
                chk($sformatf("busy_at_done[%0d]", e.val), 32'(busy), 32'd0);
            end
            last_bcd = bcd;
        end else if (bcd !== last_bcd) begin
            total++;
            bad++;
            $display("FAIL bcd_hold: got %0h expected %0h (cycle %0d)", bcd, last_bcd, cyc);
            last_bcd = bcd;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // mode 0: quiet; 1: random ignored starts and bin noise; 2: re-start with 9999 at CONV cycle 5
    task automatic run_one(input int v, input int mode);
        @(negedge clk);
        bin   = 16'(v);
        start = 1'b1;
        push_exp(v);
        for (int i = 0; i < BIN_W - 1; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_in_conv", 32'(busy), 32'd1);
            case (mode)
                1: begin
                    start = 1'($urandom_range(0, 1));
                    bin   = 16'($urandom);
                end
                2: begin
                    start = (i == 4);
                    bin   = (i == 4) ? 16'd9999 : bin;
                end
                default: start = 1'b0;
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int first_done;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_bcd", 32'(bcd), 32'd0);
        chk("reset_blank", 32'(blank), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        run_one(0, 0);
        run_one(65025, 0);
        run_one(65535, 0);
        run_one(5, 0);
        run_one(40, 2);

        // Abort a conversion with reset, then restart immediately.
        @(negedge clk);
        bin   = 16'd1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'h0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        run_one(7, 0);

        // Back-to-back: start held through the done cycle.
        @(negedge clk);
        bin   = 16'd100;
        start = 1'b1;
        push_exp(100);
        first_done = cyc + 1 + BIN_W;
        for (int i = 0; i < 40 && cyc < first_done; i++) @(negedge clk);
        bin = 16'd200;
        push_exp(200);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            run_one(int'($urandom_range(0, 65535)), 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (25) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
